result_uart_tx: RTL
===================

RESULT_UART_TX -- requirements
Module: result_uart_tx

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 868, clock cycles per UART bit (115200 baud at 100 MHz); legal range 2..65535.
REQ-002 SHALL have port clk  input  1  single system clock; all logic on rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port start  input  1  request to transmit digit_in; sampled every clk.
REQ-005 SHALL have port digit_in  input  4  recognised digit, binary 0..9.
REQ-006 SHALL have port tx  output  1  UART serial line, 8N1, idle high.
REQ-007 SHALL have port busy  output  1  high while a message is in progress.
REQ-008 SHALL have port done  output  1  one-cycle pulse when the last stop bit of a message completes.

Function
REQ-009 SHALL accept a request only in a cycle where start=1 and busy=0; it SHALL latch digit_in in that cycle.
REQ-010 SHALL ignore start while busy=1; a held-high start SHALL be re-accepted in the first cycle busy=0.
REQ-011 SHALL map digit 0..9 to ASCII 0x30..0x39; digit_in 10..15 SHALL map to 0x3F ('?').
REQ-012 SHALL use FSM states IDLE, START_BIT, DATA_BITS, STOP_BIT, NEXT_BYTE; acceptance moves IDLE->START_BIT.
REQ-013 SHALL drive tx=0 from the cycle after acceptance (latency 1) for CLKS_PER_BIT cycles (START_BIT).
REQ-014 SHALL send 8 data bits LSB first, each held exactly CLKS_PER_BIT cycles (DATA_BITS), then tx=1 for CLKS_PER_BIT cycles (STOP_BIT).
REQ-015 SHALL use a bit-timer counter that counts 0..CLKS_PER_BIT-1 and wraps, and a 3-bit bit index that wraps 7->0 on leaving DATA_BITS.
REQ-016 SHALL go STOP_BIT->NEXT_BYTE when more bytes remain, spend exactly one cycle there with tx=1, then enter START_BIT for the next byte.
REQ-017 SHALL go STOP_BIT->IDLE after the last byte; done=1 and busy=0 in the first IDLE cycle, so a new start is accepted in that same cycle.
REQ-018 SHALL hold busy=1 from the cycle after acceptance through the last STOP_BIT cycle inclusive.
REQ-019 SHALL keep tx=1 in IDLE and NEXT_BYTE; tx SHALL never glitch low outside START_BIT/DATA_BITS.
REQ-020 SHALL make done a single-cycle pulse per message, never asserted while busy=1.

Reset
REQ-021 SHALL, with rst=1 at a rising edge, set state=IDLE, tx=1, busy=0, done=0, counters=0, latched byte=0x00.
REQ-022 SHALL abort a message in progress on reset mid-frame: tx=1 from the cycle after rst is sampled, no done pulse, no resumption.
REQ-023 SHALL ignore start in any cycle where rst=1.

Configuration
REQ-024 SHALL recognise macro RESULT_TX_CRLF_EN.
REQ-025 With RESULT_TX_CRLF_EN defined, each message SHALL be 3 bytes: mapped digit, 0x0D, 0x0A, separated per REQ-016.
REQ-026 Without RESULT_TX_CRLF_EN, each message SHALL be 1 byte (mapped digit only), NEXT_BYTE unreachable.
REQ-027 Total busy length SHALL be N*10*CLKS_PER_BIT + (N-1) cycles, N = bytes per message.

Verification (CLKS_PER_BIT=4)
REQ-028 Digit 7, macro off: 1-cycle start -> tx low 4 cycles, bits 1,1,1,0,1,1,0,0 (0x37 LSB first) 4 cycles each, 4 high; busy 40 cycles; done one pulse.
REQ-029 Digit 3, macro on: -> bytes 0x33, 0x0D, 0x0A; one idle-high cycle between stop and next start bit; busy 122 cycles; one done.
REQ-030 digit_in=12 -> byte 0x3F transmitted.
REQ-031 start pulsed at cycles 5 and 20 of a 40-cycle frame -> second request ignored; start held high -> second frame starts in done cycle, tx low on next cycle.
REQ-032 rst asserted during DATA_BITS bit 3 -> tx=1, busy=0 next cycle, no done; next start transmits a clean frame.
REQ-033 digit_in changed mid-frame from 5 to 9 -> transmitted byte remains 0x35.

Source files
------------

// File: rtl/result_uart_tx.sv
// result_uart_tx: sends a recognised digit as ASCII over an 8N1 UART line.
// Optional macro RESULT_TX_CRLF_EN appends 0x0D 0x0A to every message.
//
// Parameters:
//   CLKS_PER_BIT  clock cycles per UART bit (2..65535), default 868
// Ports:
//   clk       system clock, rising edge
//   rst       synchronous active-high reset
//   start     transmit request, taken only while busy is low
//   digit_in  digit 0..9; values 10..15 are sent as '?'
//   tx        serial line, idle high
//   busy      high while a message is in progress
//   done      one-cycle pulse in the first idle cycle after a message
module result_uart_tx #(
    parameter int unsigned CLKS_PER_BIT = 868
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [3:0] digit_in,
    output logic       tx,
    output logic       busy,
    output logic       done
);

    typedef enum logic [2:0] {
        IDLE,
        START_BIT,
        DATA_BITS,
        STOP_BIT,
        NEXT_BYTE
    } state_t;

    localparam logic [15:0] LAST_CNT = 16'(CLKS_PER_BIT - 1);

    state_t      state;
    state_t      state_n;
    logic [15:0] clk_cnt;
    logic [15:0] clk_cnt_n;
    logic [2:0]  bit_idx;
    logic [2:0]  bit_idx_n;
    logic [7:0]  cur_byte;
    logic [7:0]  cur_byte_n;
    logic        tx_n;
    logic        busy_n;
    logic        done_n;
    logic        bit_end;

`ifdef RESULT_TX_CRLF_EN
    logic [1:0]  byte_idx;
    logic [1:0]  byte_idx_n;
`endif

    function automatic logic [7:0] map_digit(input logic [3:0] d);
        if (d <= 4'd9) begin
            return 8'h30 + {4'h0, d};
        end
        return 8'h3F;
    endfunction

    assign bit_end = (clk_cnt == LAST_CNT);

    // Next-state logic; outputs are derived from the next state so that
    // tx/busy/done come straight from flops and cannot glitch.
    always_comb begin
        state_n    = state;
        clk_cnt_n  = clk_cnt;
        bit_idx_n  = bit_idx;
        cur_byte_n = cur_byte;
        done_n     = 1'b0;
`ifdef RESULT_TX_CRLF_EN
        byte_idx_n = byte_idx;
`endif
        unique case (state)
            IDLE: begin
                if (start) begin
                    state_n    = START_BIT;
                    clk_cnt_n  = 16'd0;
                    bit_idx_n  = 3'd0;
                    cur_byte_n = map_digit(digit_in);
`ifdef RESULT_TX_CRLF_EN
                    byte_idx_n = 2'd0;
`endif
                end
            end
            START_BIT: begin
                if (bit_end) begin
                    clk_cnt_n = 16'd0;
                    state_n   = DATA_BITS;
                end else begin
                    clk_cnt_n = clk_cnt + 16'd1;
                end
            end
            DATA_BITS: begin
                if (bit_end) begin
                    clk_cnt_n = 16'd0;
                    // 3-bit index wraps 7->0 as the last bit ends
                    bit_idx_n = bit_idx + 3'd1;
                    if (bit_idx == 3'd7) begin
                        state_n = STOP_BIT;
                    end
                end else begin
                    clk_cnt_n = clk_cnt + 16'd1;
                end
            end
            STOP_BIT: begin
                if (bit_end) begin
                    clk_cnt_n = 16'd0;
`ifdef RESULT_TX_CRLF_EN
                    if (byte_idx != 2'd2) begin
                        state_n    = NEXT_BYTE;
                        byte_idx_n = byte_idx + 2'd1;
                        cur_byte_n = (byte_idx == 2'd0) ? 8'h0D : 8'h0A;
                    end else begin
                        state_n = IDLE;
                        done_n  = 1'b1;
                    end
`else
                    state_n = IDLE;
                    done_n  = 1'b1;
`endif
                end else begin
                    clk_cnt_n = clk_cnt + 16'd1;
                end
            end
            NEXT_BYTE: begin
                state_n = START_BIT;
            end
            default: begin
                state_n = IDLE;
            end
        endcase

        unique case (state_n)
            START_BIT: tx_n = 1'b0;
            DATA_BITS: tx_n = cur_byte_n[bit_idx_n];
            default:   tx_n = 1'b1;
        endcase
        busy_n = (state_n != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            clk_cnt  <= 16'd0;
            bit_idx  <= 3'd0;
            cur_byte <= 8'h00;
            tx       <= 1'b1;
            busy     <= 1'b0;
            done     <= 1'b0;
`ifdef RESULT_TX_CRLF_EN
            byte_idx <= 2'd0;
`endif
        end else begin
            state    <= state_n;
            clk_cnt  <= clk_cnt_n;
            bit_idx  <= bit_idx_n;
            cur_byte <= cur_byte_n;
            tx       <= tx_n;
            busy     <= busy_n;
            done     <= done_n;
`ifdef RESULT_TX_CRLF_EN
            byte_idx <= byte_idx_n;
`endif
        end
    end

endmodule
